// File: rtl/rolling_display_ctrl.sv
// Scroll sequencer for an 8-digit seven-segment display: buffers a message of
// hex codes, then slides an 8-digit window across message + 8 pad codes.
module rolling_display_ctrl #(
  parameter int         MSG_DEPTH  = 16,
  parameter int         SCROLL_DIV = 50_000_000,
  parameter logic [3:0] PAD_CODE   = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_data,
  input  logic        wr_last,
  input  logic        run,
  input  logic        clear,
  output logic [31:0] digits,
  output logic [4:0]  msg_len,
  output logic [1:0]  state,
  output logic        step_pulse
);

  localparam int                IDX_W   = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int                DIV_W   = $clog2(SCROLL_DIV);
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(SCROLL_DIV - 1);
  localparam logic [4:0]        DEPTH   = 5'(MSG_DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       msg_len_q, msg_len_d;
  logic [4:0]       offset_q, offset_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      digits_q, digits_d;
  logic [3:0]       msg_buf_q [MSG_DEPTH];

  logic       wr_fire;
  logic       step_fire;
  logic [5:0] seq_len;

  assign seq_len   = {1'b0, msg_len_q} + 6'd8;
  assign wr_ready  = (state_q == ST_LOAD) && (msg_len_q < DEPTH) && !clear;
  assign wr_fire   = wr_valid && wr_ready;
  // A step needs run still high; clear always suppresses it.
  assign step_fire = (state_q == ST_RUN) && run && (div_q == DIV_MAX) && !clear;

  assign digits     = digits_q;
  assign msg_len    = msg_len_q;
  assign state      = state_q;
  assign step_pulse = step_fire;

  always_comb begin
    state_d   = state_q;
    msg_len_d = msg_len_q;
    offset_d  = offset_q;
    div_d     = div_q;
    case (state_q)
      ST_LOAD: begin
        if (wr_fire) begin
          msg_len_d = msg_len_q + 5'd1;
          if (wr_last || (msg_len_q + 5'd1 == DEPTH)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        div_d = '0;
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_HOLD;
          div_d   = '0;
        end else if (div_q == DIV_MAX) begin
          div_d    = '0;
          offset_d = ({1'b0, offset_q} == seq_len - 6'd1) ? 5'd0 : offset_q + 5'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    if (clear) begin
      state_d   = ST_LOAD;
      msg_len_d = '0;
      offset_d  = '0;
      div_d     = '0;
    end
  end

  // Window digit k shows seq[(offset + k) mod L]; offset < L and k < 8 <= L,
  // so a single conditional subtraction performs the wrap.
  always_comb begin
    logic [5:0] idx;
    digits_d = '0;
    for (int k = 0; k < 8; k++) begin
      idx = {1'b0, offset_q} + 6'(k);
      if (idx >= seq_len) idx = idx - seq_len;
      if (idx < {1'b0, msg_len_q}) digits_d[4*k +: 4] = msg_buf_q[idx[IDX_W-1:0]];
      else                         digits_d[4*k +: 4] = PAD_CODE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      msg_len_q <= '0;
      offset_q  <= '0;
      div_q     <= '0;
      digits_q  <= {8{PAD_CODE}};
    end else begin
      state_q   <= state_d;
      msg_len_q <= msg_len_d;
      offset_q  <= offset_d;
      div_q     <= div_d;
      digits_q  <= digits_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) msg_buf_q[msg_len_q[IDX_W-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_rolling_display_ctrl.sv
// Directed bench for rolling_display_ctrl with SCROLL_DIV = 4, MSG_DEPTH = 16.
module tb_rolling_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_data = 4'h0;
  logic        wr_last = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] digits;
  logic [4:0]  msg_len;
  logic [1:0]  state;
  logic        step_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rolling_display_ctrl #(
    .MSG_DEPTH (16),
    .SCROLL_DIV(4),
    .PAD_CODE  (4'h0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .run       (run),
    .clear     (clear),
    .digits    (digits),
    .msg_len   (msg_len),
    .state     (state),
    .step_pulse(step_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step_pulse && n < 20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_digits", digits, 32'h0);
    chk("rst_state", state, 2'd0);
    chk("rst_ready", wr_ready, 1'b1);
    chk("rst_len", msg_len, 5'd0);

    wr(4'h1, 1'b0);
    wr(4'h2, 1'b0);
    wr(4'h3, 1'b1);
    chk("load3_state", state, 2'd1);
    chk("load3_len", msg_len, 5'd3);
    chk("hold_ready", wr_ready, 1'b0);
    tick();
    chk("load3_digits", digits, 32'h0000_0321);

    run = 1'b1;
    tick();
    chk("run_state", state, 2'd2);
    chk("run_no_step", step_pulse, 1'b0);
    wait_pulse(n);
    chk("gap_first", n, 3);
    wait_pulse(n);
    chk("gap_2", n, 4);
    chk("step1_digits", digits, 32'h0000_0032);
    for (int i = 3; i <= 12; i++) begin
      wait_pulse(n);
      chk("gap_n", n, 4);
      if (i == 11) chk("step10_digits", digits, 32'h0000_3210);
      if (i == 12) chk("wrap_digits", digits, 32'h0000_0321);
    end

    tick();
    tick();
    chk("pre_freeze", digits, 32'h0000_0032);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("freeze_state", state, 2'd1);
      chk("freeze_digits", digits, 32'h0000_0032);
    end
    run = 1'b1;
    tick();
    chk("rerun_state", state, 2'd2);
    wait_pulse(n);
    chk("rerun_gap", n, 3);

    repeat (4) tick();
    chk("pre_clear_step", step_pulse, 1'b1);
    clear = 1'b1;
    #1;
    chk("clear_beats_step", step_pulse, 1'b0);
    tick();
    clear = 1'b0;
    run   = 1'b0;
    chk("clear_state", state, 2'd0);
    chk("clear_len", msg_len, 5'd0);
    tick();
    chk("clear_digits", digits, 32'h0);

    for (int i = 0; i < 16; i++) wr(4'(i), 1'b0);
    chk("full_state", state, 2'd1);
    chk("full_len", msg_len, 5'd16);
    chk("full_ready", wr_ready, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 4'hF;
    tick();
    wr_valid = 1'b0;
    chk("over_len", msg_len, 5'd16);
    chk("over_digits", digits, 32'h7654_3210);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    wr(4'h5, 1'b0);
    wr(4'h6, 1'b0);
    chk("two_len", msg_len, 5'd2);
    wr_valid = 1'b1;
    wr_data  = 4'h7;
    clear    = 1'b1;
    #1;
    chk("clr_wr_ready", wr_ready, 1'b0);
    tick();
    wr_valid = 1'b0;
    clear    = 1'b0;
    chk("clr_wr_len", msg_len, 5'd0);
    chk("clr_wr_state", state, 2'd0);
    tick();
    chk("clr_wr_digits", digits, 32'h0);

    wr(4'h9, 1'b1);
    chk("one_state", state, 2'd1);
    run = 1'b1;
    tick();
    tick();
    chk("one_run", state, 2'd2);
    chk("one_digits", digits, 32'h0000_0009);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_state", state, 2'd0);
    chk("mid_rst_len", msg_len, 5'd0);
    chk("mid_rst_step", step_pulse, 1'b0);
    rst_n = 1'b1;
    run   = 1'b0;
    tick();
    chk("mid_rst_digits", digits, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
